// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO depth derivation, threshold range limits and access classification
package fifo_pkg;

  // Kind of access accepted on a given edge; drives the occupancy counter.
  typedef enum logic [1:0] {
    ACC_NONE = 2'b00,
    ACC_WR   = 2'b01,
    ACC_RD   = 2'b10,
    ACC_BOTH = 2'b11
  } fifo_acc_e;

  // Lowest legal almost-full and almost-empty levels.
  localparam int AF_THRESH_MIN = 1;
  localparam int AE_THRESH_MIN = 0;

  // Number of entries for a given address width.
  function automatic int fifo_depth(input int asize);
    return 1 << asize;
  endfunction

  // Highest legal almost-full level: the FIFO depth itself.
  function automatic int af_thresh_max(input int asize);
    return fifo_depth(asize);
  endfunction

  // Highest legal almost-empty level: one below the FIFO depth.
  function automatic int ae_thresh_max(input int asize);
    return fifo_depth(asize) - 1;
  endfunction

  // Pull an out-of-range threshold back into its legal window so a bad
  // parameter never produces a flag that can never (or always) assert.
  function automatic int clamp_thresh(input int value, input int lo, input int hi);
    if (value < lo) begin
      return lo;
    end
    if (value > hi) begin
      return hi;
    end
    return value;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - 2**ASIZE x DSIZE storage, synchronous write, asynchronous read
module sync_fifo_mem #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [ASIZE-1:0] i_waddr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic [ASIZE-1:0] i_raddr,
  output logic [DSIZE-1:0] o_rdata
);

  logic [DSIZE-1:0] r_mem [2**ASIZE];

  // Storage is deliberately never reset; only the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_level.sv
// rtl/sync_fifo_level.sv - single-clock FIFO with level counter, thresholds and sticky errors; SYNC_FIFO_FWFT_EN selects fall-through read
module sync_fifo_level
  import fifo_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AF_THRESH = (1 << ASIZE) - 2,
  parameter int AE_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   level,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int DEPTH  = fifo_depth(ASIZE);
  localparam int AF_EFF = clamp_thresh(AF_THRESH, AF_THRESH_MIN, af_thresh_max(ASIZE));
  localparam int AE_EFF = clamp_thresh(AE_THRESH, AE_THRESH_MIN, ae_thresh_max(ASIZE));

  localparam logic [ASIZE:0] DEPTH_LVL = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_LVL    = (ASIZE+1)'(AF_EFF);
  localparam logic [ASIZE:0] AE_LVL    = (ASIZE+1)'(AE_EFF);
  localparam logic [ASIZE:0] ONE_LVL   = (ASIZE+1)'(1);

  // Pointers carry one extra MSB so equal addresses can still tell a
  // wrapped (full) FIFO from an empty one.
  logic [ASIZE:0]   r_wptr;
  logic [ASIZE:0]   r_rptr;
  logic [ASIZE:0]   r_level;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_mem_we;
  logic [DSIZE-1:0] w_mem_rdata;
  fifo_acc_e        w_acc;

  // Status flags come straight from the registered level.
  assign wfull         = (r_level == DEPTH_LVL);
  assign rempty        = (r_level == '0);
  assign walmost_full  = (r_level >= AF_LVL);
  assign ralmost_empty = (r_level <= AE_LVL);
  assign level         = r_level;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

  // A write into a full FIFO is dropped and a read from an empty one is
  // ignored, independently of what the other port does in that cycle.
  assign w_wr_acc = winc & ~wfull;
  assign w_rd_acc = rinc & ~rempty;
  assign w_mem_we = w_wr_acc & ~rst;

  // Classify the accepted access pair for the level update.
  always_comb begin
    w_acc = ACC_NONE;
    unique case ({w_rd_acc, w_wr_acc})
      2'b01:   w_acc = ACC_WR;
      2'b10:   w_acc = ACC_RD;
      2'b11:   w_acc = ACC_BOTH;
      default: w_acc = ACC_NONE;
    endcase
  end

  // Advance write/read pointers on accepted accesses; reset wins over both.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + ONE_LVL;
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + ONE_LVL;
      end
    end
  end

  // Occupancy counter: simultaneous write and read leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= '0;
    end else begin
      unique case (w_acc)
        ACC_WR:  r_level <= r_level + ONE_LVL;
        ACC_RD:  r_level <= r_level - ONE_LVL;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky error flags; a clear in the same cycle as a new error wins.
  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (winc && wfull) begin
        r_overflow <= 1'b1;
      end
      if (rinc && rempty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  sync_fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wptr[ASIZE-1:0]),
    .i_wdata (wdata),
    .i_raddr (r_rptr[ASIZE-1:0]),
    .o_rdata (w_mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is visible as soon as it is stored; rinc consumes it.
  assign rdata = rempty ? '0 : w_mem_rdata;
`else
  logic [DSIZE-1:0] r_rdata;

  // Capture the head word on the accepting edge and hold it until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_rd_acc) begin
      r_rdata <= w_mem_rdata;
    end
  end

  assign rdata = r_rdata;
`endif

  // The pointer distance must always agree with the level counter.
  a_ptr_level : assert property (@(posedge clk) disable iff (rst)
    (r_wptr - r_rptr) == r_level);

endmodule

// File: doc/sync_fifo_level.md
SYNC_FIFO_LEVEL -- requirements
Module: sync_fifo_level

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DSIZE, 8, data width in bits.
- ASIZE, 4, address width; depth DEPTH = 2**ASIZE.
- AF_THRESH, 2**ASIZE-2, almost-full level; legal range 1..DEPTH.
- AE_THRESH, 2, almost-empty level; legal range 0..DEPTH-1.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, synchronous active-high reset.
- wdata, in, DSIZE, write data.
- winc, in, 1, write request.
- wfull, out, 1, FIFO holds DEPTH entries.
- walmost_full, out, 1, level >= AF_THRESH.
- rinc, in, 1, read/pop request.
- rdata, out, DSIZE, read data.
- rempty, out, 1, FIFO holds 0 entries.
- ralmost_empty, out, 1, level <= AE_THRESH.
- level, out, ASIZE+1, current entry count, 0..DEPTH.
- overflow, out, 1, sticky: write attempted while full.
- underflow, out, 1, sticky: read attempted while empty.
- clr_err, in, 1, clears overflow/underflow.
REQ-003 The block SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-004 A write SHALL be accepted iff winc && !wfull: stores wdata at waddr, then waddr increments modulo DEPTH.
REQ-005 A read SHALL be accepted iff rinc && !rempty: raddr increments modulo DEPTH.
REQ-006 Pointers SHALL be ASIZE+1 bits; the extra MSB distinguishes full from empty on wrap-around.
REQ-007 level SHALL be a registered counter: +1 on a write-only accept, -1 on a read-only accept, unchanged when both or neither are accepted.
REQ-008 wfull, rempty, walmost_full and ralmost_empty SHALL decode combinationally from registered level; they are valid in the cycle after the causing edge.
REQ-009 A write while wfull SHALL be dropped even if a read is accepted in the same cycle; the read proceeds.
REQ-010 A read while rempty SHALL be ignored even if a write is accepted in the same cycle; the write proceeds.
REQ-011 overflow SHALL set on the cycle after winc && wfull; underflow SHALL set on the cycle after rinc && rempty.
REQ-012 Sticky flags SHALL hold until clr_err or rst; when set and clear coincide, clear SHALL win.
REQ-013 The default read mode SHALL register rdata: it is loaded with mem[raddr] on the edge accepting a read, valid the next cycle, and held otherwise.

Reset
REQ-014 On rst: pointers=0, level=0, rempty=1, ralmost_empty=1, wfull=0, walmost_full=0, overflow=0, underflow=0, rdata=0.
REQ-015 rst SHALL override winc/rinc in the same cycle; storage contents SHALL NOT be reset.
REQ-016 rst asserted mid-operation SHALL discard all entries; the first write after reset SHALL be the first read.

Configuration
REQ-017 With SYNC_FIFO_FWFT_EN defined, rdata SHALL equal mem[raddr] combinationally while !rempty (first-word fall-through), and rinc SHALL pop that word.
REQ-018 Without SYNC_FIFO_FWFT_EN, REQ-013 behaviour applies; all flags and level SHALL be identical in both modes.

Structure
REQ-019 Shared package fifo_pkg SHALL hold the DEPTH derivation and the threshold-range check constants, reused by future FIFO variants.
REQ-020 Storage SHALL be a sub-module sync_fifo_mem: a 2**ASIZE x DSIZE array with a synchronous write port and an asynchronous read port.

Verification (DSIZE=8, ASIZE=4, AF_THRESH=14, AE_THRESH=2)
REQ-021 Write 0x00..0x0F with no reads -> wfull=1 after the 16th write, level=16, walmost_full=1 from level 14; a 17th write sets overflow and data is unchanged.
REQ-022 Read all 16 entries -> data 0x00..0x0F in order (1-cycle latency; 0-cycle with FWFT), rempty=1 after the last read; an extra rinc sets underflow.
REQ-023 At level=8, winc and rinc together for 40 cycles -> level stays 8, pointers wrap past 15, and data order is preserved.
REQ-024 Full FIFO with winc and rinc together -> read accepted, write dropped, level=15, overflow=1; clr_err -> overflow=0.
REQ-025 rst pulsed at level=5 during winc -> level=0, rempty=1, rdata=0; the next written 0xA5 is the next word read.
